// File: rtl/ram2_index_reader.sv
//==============================================================================
// Module      : ram2_index_reader
// Description : Decompress-side reader for the codebook-index RAM (RAM2).
//               For every image block it fetches the block's codebook index
//               from RAM2 and copies the matching codeword pixels from the
//               codebook RAM (RAM1) into the reconstructed-image RAM (RAM3).
//               RAM2 is only ever read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   start    in   begin decoding one image (sampled in IDLE only)
//   RAM2_A   out  index-RAM read address (block number)
//   RAM2_WE  out  index-RAM write enable, tied low
//   RAM2_Q   in   index-RAM read data
//   CB_A     out  codebook address = idx*BLOCK_PIX + pixel
//   CB_Q     in   codebook read data
//   RAM3_A   out  reconstructed-image write address
//   RAM3_D   out  reconstructed-image write data
//   RAM3_WE  out  reconstructed-image write enable
//   busy     out  high while an image is being decoded
//   done     out  one-cycle completion pulse
//==============================================================================
`default_nettype none

module ram2_index_reader #(
    parameter int ADDR_W     = 20,
    parameter int IDX_W      = 8,
    parameter int PIX_W      = 8,
    parameter int BLOCK_PIX  = 16,
    parameter int NUM_BLOCKS = 16384,
    parameter int RD_LAT     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic [ADDR_W-1:0]                    RAM2_A,
    output logic                                 RAM2_WE,
    input  logic [IDX_W-1:0]                     RAM2_Q,
    output logic [IDX_W+$clog2(BLOCK_PIX)-1:0]   CB_A,
    input  logic [PIX_W-1:0]                     CB_Q,
    output logic [ADDR_W-1:0]                    RAM3_A,
    output logic [PIX_W-1:0]                     RAM3_D,
    output logic                                 RAM3_WE,
    output logic                                 busy,
    output logic                                 done
);

    localparam int PIX_AW = $clog2(BLOCK_PIX);
    localparam int CNT_W  = $clog2(RD_LAT + 2);

    localparam logic [ADDR_W-1:0] C_LAST_BLK   = ADDR_W'(NUM_BLOCKS - 1);
    localparam logic [CNT_W-1:0]  C_WAIT_LAST  = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0]  C_DRAIN_LAST = CNT_W'(RD_LAT + 1);
    localparam logic [PIX_AW-1:0] C_PIX_LAST   = PIX_AW'(BLOCK_PIX - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_COPY  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                         state_q;
    logic [ADDR_W-1:0]              blk_q;
    logic [PIX_AW-1:0]              pix_q;
    logic [IDX_W-1:0]               idx_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [ADDR_W-1:0]              ram2_a_q;
    logic [IDX_W+PIX_AW-1:0]        cb_a_q;
    logic                           busy_q;
    logic                           done_q;

    // Write pipeline: one stage per cycle of codebook read latency, each
    // carrying "this slot holds a pixel" and the pixel offset inside the block.
    logic [RD_LAT-1:0]              dl_v_q;
    logic [PIX_AW-1:0]              dl_p_q [RD_LAT];
    logic [ADDR_W-1:0]              ram3_a_q;
    logic [PIX_W-1:0]               ram3_d_q;
    logic                           ram3_we_q;

    logic [ADDR_W-1:0]              w_ram3_a;

    // blk*BLOCK_PIX + p as a shift/concatenation, truncated to ADDR_W.
    assign w_ram3_a = {blk_q[ADDR_W-PIX_AW-1:0], dl_p_q[RD_LAT-1]};

    //--------------------------------------------------------------------------
    // Block sequencer
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            blk_q    <= '0;
            pix_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            ram2_a_q <= '0;
            cb_a_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        blk_q    <= '0;
                        ram2_a_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                end

                // Address has been on RAM2_A since the previous edge.
                S_FETCH: begin
                    cnt_q   <= CNT_W'(1);
                    state_q <= S_WAIT;
                end

                // RAM2_Q is valid in the cycle where cnt_q reaches RD_LAT.
                S_WAIT: begin
                    if (cnt_q == C_WAIT_LAST) begin
                        idx_q   <= RAM2_Q;
                        cb_a_q  <= {RAM2_Q, {PIX_AW{1'b0}}};
                        pix_q   <= PIX_AW'(1);
                        state_q <= S_COPY;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // One codebook address per cycle; leave once the last pixel
                // address of the codeword is on the bus.
                S_COPY: begin
                    if (cb_a_q[PIX_AW-1:0] == C_PIX_LAST) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= S_DRAIN;
                    end else begin
                        cb_a_q <= {idx_q, pix_q};
                        pix_q  <= pix_q + PIX_AW'(1);
                    end
                end

                // Let the outstanding codebook reads reach RAM3.
                S_DRAIN: begin
                    if (cnt_q == C_DRAIN_LAST) begin
                        if (blk_q == C_LAST_BLK) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            blk_q    <= blk_q + ADDR_W'(1);
                            ram2_a_q <= blk_q + ADDR_W'(1);
                            state_q  <= S_FETCH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // start is deliberately not sampled here; a held start is
                // seen one cycle later in IDLE.
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Codebook-read to RAM3-write pipeline
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_v_q    <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                dl_p_q[k] <= '0;
            end
            ram3_a_q  <= '0;
            ram3_d_q  <= '0;
            ram3_we_q <= 1'b0;
        end else begin
            // CB_A carries a real pixel address exactly in the COPY cycles.
            dl_v_q[0] <= (state_q == S_COPY);
            dl_p_q[0] <= cb_a_q[PIX_AW-1:0];
            for (int k = 1; k < RD_LAT; k++) begin
                dl_v_q[k] <= dl_v_q[k-1];
                dl_p_q[k] <= dl_p_q[k-1];
            end

            ram3_we_q <= dl_v_q[RD_LAT-1];
            if (dl_v_q[RD_LAT-1]) begin
                ram3_a_q <= w_ram3_a;
                ram3_d_q <= CB_Q;
            end
        end
    end

    assign RAM2_A  = ram2_a_q;
    assign RAM2_WE = 1'b0;
    assign CB_A    = cb_a_q;
    assign RAM3_A  = ram3_a_q;
    assign RAM3_D  = ram3_d_q;
    assign RAM3_WE = ram3_we_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

`default_nettype wire
